// File: rtl/pipe_hazard_unit_pkg.sv
// pipe_pkg: shared definitions for the pipeline hazard controller.
//   - Stage index constants for the fixed front of the pipe (F, D, E) and
//     the write-back stage of the default 5-stage configuration.
//   - FSELW: forwarding-select width for the default depth.
//   - sb_entry_t: one scoreboard entry {valid, dst, wr, ld}; dst is sized
//     for the widest supported register address and narrower addresses are
//     zero-extended into it.
package pipe_pkg;

  localparam int unsigned NSTAGES_DEF = 5;

  localparam int unsigned ST_F = 0;
  localparam int unsigned ST_D = 1;
  localparam int unsigned ST_E = 2;
  localparam int unsigned ST_W = NSTAGES_DEF - 1;

  localparam int unsigned FSELW = $clog2(NSTAGES_DEF);

  localparam int unsigned DSTW_MAX = 8;

  typedef struct packed {
    logic                valid;
    logic [DSTW_MAX-1:0] dst;
    logic                wr;
    logic                ld;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_fwd_match.sv
// fwd_match: priority match of one source register against the scoreboard
// stages older than consumer stage CONS.
//   i_sb      scoreboard entries for stages CONS+1 .. NSTAGES-1
//   i_src     source register (zero-extended), i_use: source is read
//   i_rdy     a load match at a stage below this index is not forwardable
//   i_near    any match in the stage directly behind the consumer blocks
//   o_sel     youngest matching stage, 0 if none or if blocked
//   o_haz     youngest match cannot be forwarded this cycle
module fwd_match
  import pipe_pkg::*;
#(
  parameter int unsigned NSTAGES = 5,
  parameter int unsigned CONS    = 1,
  parameter int unsigned SELW    = 3
) (
  input  sb_entry_t [NSTAGES-1:CONS+1] i_sb,
  input  logic [DSTW_MAX-1:0]          i_src,
  input  logic                         i_use,
  input  logic [SELW-1:0]              i_rdy,
  input  logic                         i_near,
  output logic [SELW-1:0]              o_sel,
  output logic                         o_haz
);

  logic [SELW-1:0] w_hit_stage;
  logic            w_hit_ld;
  logic            w_hit;

  always_comb begin
    w_hit_stage = '0;
    w_hit_ld    = 1'b0;
    // Walk oldest to youngest so the youngest producer wins.
    for (int unsigned s = NSTAGES - 1; s > CONS; s--) begin
      if (i_use && (i_src != '0) && i_sb[s].valid && i_sb[s].wr &&
          (i_sb[s].dst == i_src)) begin
        w_hit_stage = SELW'(s);
        w_hit_ld    = i_sb[s].ld;
      end
    end
    w_hit = (w_hit_stage != '0);
    o_haz = w_hit && ((w_hit_ld && (w_hit_stage < i_rdy)) ||
                      (i_near && (w_hit_stage == SELW'(CONS + 1))));
    o_sel = o_haz ? '0 : w_hit_stage;
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard, forwarding and stall/flush controller for the
// in-order pipeline. Tracks each stage's destination in a scoreboard.
//   clk, rst            clock, asynchronous active-high reset
//   i_stall, d_stall    bus busy: freeze the whole pipe
//   div_stall           multicycle ALU busy in E
//   dec_*               instruction currently in D
//   exc_req             exception raised at EXC_STAGE
//   stall, flush        per-stage hold / bubble
//   exc_flush           one-cycle PC redirect pulse
//   fwd_aD..fwd_bE      forwarding source stage (0 = register file)
//   longest_stall       any stall this cycle
//   max_stall           longest run of consecutive stall cycles
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned NSTAGES   = 5,
  parameter int unsigned REGW      = 5,
  parameter int unsigned LOAD_RDY  = NSTAGES - 1,
  parameter int unsigned EXC_STAGE = 3,
  parameter int unsigned CNTW      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_stall,
  input  logic                       d_stall,
  input  logic                       div_stall,
  input  logic                       dec_valid,
  input  logic                       dec_branch,
  input  logic [REGW-1:0]            dec_rs,
  input  logic [REGW-1:0]            dec_rt,
  input  logic                       dec_use_rs,
  input  logic                       dec_use_rt,
  input  logic [REGW-1:0]            dec_dst,
  input  logic                       dec_wr,
  input  logic                       dec_ld,
  input  logic                       exc_req,
  output logic [NSTAGES-1:0]         stall,
  output logic [NSTAGES-1:0]         flush,
  output logic                       exc_flush,
  output logic [$clog2(NSTAGES)-1:0] fwd_aD,
  output logic [$clog2(NSTAGES)-1:0] fwd_bD,
  output logic [$clog2(NSTAGES)-1:0] fwd_aE,
  output logic [$clog2(NSTAGES)-1:0] fwd_bE,
  output logic                       longest_stall,
  output logic [CNTW-1:0]            max_stall
);

  localparam int unsigned SELW = $clog2(NSTAGES);
  // A branch reads in D now; any other D instruction reads one cycle later
  // in E, so a load one stage short of ready does not block it.
  localparam int unsigned RDY_D_BR = (LOAD_RDY > ST_E + 1) ? LOAD_RDY : ST_E + 1;
  localparam int unsigned RDY_D_NB = (LOAD_RDY > ST_E + 2) ? LOAD_RDY - 1 : ST_E + 1;
  localparam logic [NSTAGES-1:0] EXC_MASK = NSTAGES'((64'd1 << (EXC_STAGE + 1)) - 64'd1);
  localparam logic [NSTAGES-1:0] D_HOLD   = NSTAGES'(3);
  localparam logic [NSTAGES-1:0] E_HOLD   = NSTAGES'(7);

  sb_entry_t [NSTAGES-1:ST_E] r_sb;
  logic [REGW-1:0]            r_e_rs;
  logic [REGW-1:0]            r_e_rt;
  logic [1:0]                 r_e_use;
  logic                       r_pend;
  logic [CNTW-1:0]            r_run;
  logic [CNTW-1:0]            r_max;

  sb_entry_t                  w_dec_ent;
  logic [SELW-1:0]            w_rdy_d;
  logic [SELW-1:0]            w_sel_aD, w_sel_bD, w_sel_aE, w_sel_bE;
  logic                       w_haz_aD, w_haz_bD, w_haz_aE, w_haz_bE;
  logic                       w_bus, w_exc, w_ehaz, w_dhaz, w_excf;
  logic [NSTAGES-1:0]         w_stall, w_flush;
  logic [CNTW-1:0]            w_run_inc;

  always_comb begin
    w_dec_ent.valid = dec_valid;
    w_dec_ent.dst   = DSTW_MAX'(dec_dst);
    w_dec_ent.wr    = dec_wr;
    w_dec_ent.ld    = dec_ld;
    w_rdy_d = dec_branch ? SELW'(RDY_D_BR) : SELW'(RDY_D_NB);
  end

  fwd_match #(.NSTAGES(NSTAGES), .CONS(ST_D), .SELW(SELW)) u_fwd_aD (
    .i_sb(r_sb[NSTAGES-1:ST_D+1]), .i_src(DSTW_MAX'(dec_rs)),
    .i_use(dec_valid & dec_use_rs), .i_rdy(w_rdy_d), .i_near(dec_branch),
    .o_sel(w_sel_aD), .o_haz(w_haz_aD));

  fwd_match #(.NSTAGES(NSTAGES), .CONS(ST_D), .SELW(SELW)) u_fwd_bD (
    .i_sb(r_sb[NSTAGES-1:ST_D+1]), .i_src(DSTW_MAX'(dec_rt)),
    .i_use(dec_valid & dec_use_rt), .i_rdy(w_rdy_d), .i_near(dec_branch),
    .o_sel(w_sel_bD), .o_haz(w_haz_bD));

  fwd_match #(.NSTAGES(NSTAGES), .CONS(ST_E), .SELW(SELW)) u_fwd_aE (
    .i_sb(r_sb[NSTAGES-1:ST_E+1]), .i_src(DSTW_MAX'(r_e_rs)),
    .i_use(r_sb[ST_E].valid & r_e_use[0]), .i_rdy(SELW'(LOAD_RDY)), .i_near(1'b0),
    .o_sel(w_sel_aE), .o_haz(w_haz_aE));

  fwd_match #(.NSTAGES(NSTAGES), .CONS(ST_E), .SELW(SELW)) u_fwd_bE (
    .i_sb(r_sb[NSTAGES-1:ST_E+1]), .i_src(DSTW_MAX'(r_e_rt)),
    .i_use(r_sb[ST_E].valid & r_e_use[1]), .i_rdy(SELW'(LOAD_RDY)), .i_near(1'b0),
    .o_sel(w_sel_bE), .o_haz(w_haz_bE));

  always_comb begin
    w_bus   = i_stall | d_stall;
    w_exc   = exc_req | r_pend;
    w_ehaz  = div_stall | w_haz_aE | w_haz_bE;
    w_dhaz  = w_haz_aD | w_haz_bD;
    w_stall = '0;
    w_flush = '0;
    w_excf  = 1'b0;
    if (w_bus) begin
      w_stall = '1;
    end else if (w_exc) begin
      w_flush = EXC_MASK;
      w_excf  = 1'b1;
    end else if (w_ehaz) begin
      w_stall = E_HOLD;
      w_flush[ST_E+1] = 1'b1;
    end else if (w_dhaz) begin
      w_stall = D_HOLD;
      w_flush[ST_E] = 1'b1;
    end
    w_run_inc = (&r_run) ? r_run : r_run + 1'b1;
  end

  // Outputs read zero throughout reset even if stall inputs stay asserted.
  always_comb begin
    stall         = rst ? '0 : w_stall;
    flush         = rst ? '0 : w_flush;
    exc_flush     = rst ? 1'b0 : w_excf;
    fwd_aD        = rst ? '0 : w_sel_aD;
    fwd_bD        = rst ? '0 : w_sel_bD;
    fwd_aE        = rst ? '0 : w_sel_aE;
    fwd_bE        = rst ? '0 : w_sel_bE;
    longest_stall = |stall;
    max_stall     = r_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb    <= '0;
      r_e_rs  <= '0;
      r_e_rt  <= '0;
      r_e_use <= '0;
      r_pend  <= 1'b0;
      r_run   <= '0;
      r_max   <= '0;
    end else begin
      if (w_flush[ST_E]) begin
        r_sb[ST_E] <= '0;
        r_e_use    <= '0;
      end else if (!w_stall[ST_D]) begin
        r_sb[ST_E] <= w_dec_ent;
        r_e_rs     <= dec_rs;
        r_e_rt     <= dec_rt;
        r_e_use    <= {dec_use_rt, dec_use_rs};
      end
      for (int unsigned s = ST_E + 1; s < NSTAGES; s++) begin
        if (w_flush[s])          r_sb[s] <= '0;
        else if (!w_stall[s-1])  r_sb[s] <= r_sb[s-1];
      end
      // Pending exception is either issued this cycle or still waiting on the bus.
      r_pend <= w_bus ? (r_pend | exc_req) : 1'b0;
      if (|w_stall) begin
        r_run <= w_run_inc;
        if (w_run_inc > r_max) r_max <= w_run_inc;
      end else begin
        r_run <= '0;
      end
    end
  end

endmodule
